spi_pwm_config: RTL and testbench

//  SPI (mode 0, write-only) target that configures the PWM peripheral's register bank.

---
 rtl/spi_pwm_config.sv | 149 ++++++++++++++
 tb/tb_spi_pwm_config.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_config.sv
// SPI mode-0 write-only target that loads the PWM configuration register bank.
// All SPI pins are synchronized into clk; frames commit on the nCS rising edge.
module spi_pwm_config #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = FRAME_BITS - DATA_W - 1;
  localparam int unsigned CNT_MAX = FRAME_BITS + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_fall, ncs_rise;

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [DATA_W-1:0]      regs_d [NUM_REGS];
  logic                   wr_strobe_q, wr_strobe_d;
  logic                   frame_err_q, frame_err_d;
  logic [ADDR_W-1:0]      addr;
  logic                   frame_ok;

  // Input synchronizers plus one history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;

  assign addr     = sr_q[FRAME_BITS-2 -: ADDR_W];
  assign frame_ok = (cnt_q == CNT_W'(FRAME_BITS)) && sr_q[FRAME_BITS-1] &&
                    (addr < ADDR_W'(NUM_REGS));

  // State, shift register, counter and register bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      wr_strobe_q <= wr_strobe_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  // Frame FSM: capture bits while selected, then validate and commit once
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise && !ncs_s) begin
          sr_d = {sr_q[FRAME_BITS-2:0], copi_s};
          if (cnt_q != CNT_W'(CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        if (frame_ok) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) regs_d[i] = sr_q[DATA_W-1:0];
          end
          wr_strobe_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        // A new selection arriving during commit starts the next frame directly
        if (ncs_fall) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign wr_strobe       = wr_strobe_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_pwm_config.sv
// Self-checking bench for spi_pwm_config: directed scenarios plus random frames
// checked against a frame-level model of the register bank.
module tb_spi_pwm_config;

  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe, frame_err;

  spi_pwm_config dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int err_seen = 0;
  int exp_wr = 0;
  int exp_err = 0;
  logic [7:0] model [5];
  logic [7:0] dut_regs [5];

  assign dut_regs[0] = en_reg_out_7_0;
  assign dut_regs[1] = en_reg_out_15_8;
  assign dut_regs[2] = en_reg_pwm_7_0;
  assign dut_regs[3] = en_reg_pwm_15_8;
  assign dut_regs[4] = pwm_duty_cycle;

  // Count strobe-high cycles; each frame must give exactly one cycle
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) wr_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  // Frame-level reference: a 16-bit write to an existing address updates it
  function automatic void model_apply(input logic [16:0] val, input int nbits);
    int addr;
    addr = int'(val[14:8]);
    if (nbits == 16 && val[15] && addr < 5) begin
      model[addr] = val[7:0];
      exp_wr++;
    end else begin
      exp_err++;
    end
  endfunction

  // Drive one frame at SCLK = clk/4; called and returns at a negedge
  task automatic send_frame(input logic [16:0] val, input int nbits, input int hi_clks);
    ncs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = val[i];
      repeat (2) @(negedge clk);
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (2) @(negedge clk);
    ncs = 1'b1;
    repeat (hi_clks) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_regs[i] !== model[i]) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected %h", i, dut_regs[i], model[i]);
      end
    end
    checks++;
    if (wr_strobe !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got %b%b expected 00", wr_strobe, frame_err);
    end
    rst = 1'b0;
    @(negedge clk);
    send_frame(17'h08377, 16, 8); model_apply(17'h08377, 16);
    checks++;
    if (en_reg_pwm_15_8 !== model[3]) begin
      errors++; $display("FAIL pre_reset_write: got %h expected %h", en_reg_pwm_15_8, model[3]);
    end
    // Partial frame, then reset while still selected
    ncs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 15; i >= 9; i--) begin
      copi = i[0];
      repeat (2) @(negedge clk); sclk = 1'b1;
      repeat (2) @(negedge clk); sclk = 1'b0;
    end
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_regs[i] !== model[i]) begin
        errors++; $display("FAIL midframe_reset_reg%0d: got %h expected %h", i, dut_regs[i], model[i]);
      end
    end
    checks++;
    if (wr_seen !== exp_wr || err_seen !== exp_err) begin
      errors++; $display("FAIL midframe_reset_strobes: got wr=%0d err=%0d expected wr=%0d err=%0d",
                         wr_seen, err_seen, exp_wr, exp_err);
    end
    send_frame(17'h08155, 16, 8); model_apply(17'h08155, 16);
    checks++;
    if (en_reg_out_15_8 !== 8'h55) begin
      errors++; $display("FAIL post_reset_write: got %h expected 55", en_reg_out_15_8);
    end
  endtask

  task automatic test_single_write();
    int wr0 = wr_seen;
    send_frame(17'h080FF, 16, 8); model_apply(17'h080FF, 16);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_regs[i] !== model[i]) begin
        errors++; $display("FAIL single_write_reg%0d: got %h expected %h", i, dut_regs[i], model[i]);
      end
    end
    checks++;
    if (wr_seen - wr0 !== 1) begin
      errors++; $display("FAIL single_write_strobe: got %0d expected 1", wr_seen - wr0);
    end
  endtask

  task automatic test_duty_updates();
    int wr0 = wr_seen;
    send_frame(17'h08480, 16, 8); model_apply(17'h08480, 16);
    checks++;
    if (pwm_duty_cycle !== 8'h80) begin
      errors++; $display("FAIL duty_first: got %h expected 80", pwm_duty_cycle);
    end
    send_frame(17'h08401, 16, 8); model_apply(17'h08401, 16);
    checks++;
    if (pwm_duty_cycle !== 8'h01) begin
      errors++; $display("FAIL duty_second: got %h expected 01", pwm_duty_cycle);
    end
    checks++;
    if (wr_seen - wr0 !== 2) begin
      errors++; $display("FAIL duty_strobes: got %0d expected 2", wr_seen - wr0);
    end
  endtask

  task automatic test_invalid_frames();
    int wr0 = wr_seen;
    int er0 = err_seen;
    send_frame(17'h002AA, 16, 8); model_apply(17'h002AA, 16);
    send_frame(17'h08555, 16, 8); model_apply(17'h08555, 16);
    send_frame(17'h040AA, 15, 8); model_apply(17'h040AA, 15);
    send_frame({16'h82F0, 1'b1}, 17, 8); model_apply({16'h82F0, 1'b1}, 17);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_regs[i] !== model[i]) begin
        errors++; $display("FAIL invalid_reg%0d: got %h expected %h", i, dut_regs[i], model[i]);
      end
    end
    checks++;
    if (err_seen - er0 !== 4 || wr_seen - wr0 !== 0) begin
      errors++; $display("FAIL invalid_strobes: got err=%0d wr=%0d expected err=4 wr=0",
                         err_seen - er0, wr_seen - wr0);
    end
  endtask

  task automatic test_latency();
    int lat = 0;
    send_frame(17'h08299, 16, 0); model_apply(17'h08299, 16);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (wr_strobe === 1'b1 && lat == 0) lat = i;
    end
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL latency: got %0d cycles expected 4", lat);
    end
    checks++;
    if (en_reg_pwm_7_0 !== model[2]) begin
      errors++; $display("FAIL latency_reg: got %h expected %h", en_reg_pwm_7_0, model[2]);
    end
  endtask

  task automatic test_back_to_back();
    int wr0 = wr_seen;
    send_frame(17'h08112, 16, 1); model_apply(17'h08112, 16);
    send_frame(17'h08334, 16, 8); model_apply(17'h08334, 16);
    checks++;
    if (en_reg_out_15_8 !== 8'h12 || en_reg_pwm_15_8 !== 8'h34) begin
      errors++; $display("FAIL back_to_back: got %h/%h expected 12/34", en_reg_out_15_8, en_reg_pwm_15_8);
    end
    checks++;
    if (wr_seen - wr0 !== 2) begin
      errors++; $display("FAIL back_to_back_strobes: got %0d expected 2", wr_seen - wr0);
    end
  endtask

  task automatic test_random();
    logic [16:0] val;
    int nb, hi, r;
    for (int n = 0; n < 24; n++) begin
      r = int'($urandom_range(0, 9));
      nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      val = 17'($urandom);
      if (nb == 16) begin
        val[15]   = ($urandom_range(0, 3) != 0);
        val[14:8] = 7'($urandom_range(0, 6));
      end
      hi = int'($urandom_range(1, 8));
      send_frame(val, nb, hi); model_apply(val, nb);
      if (hi >= 5) begin
        for (int i = 0; i < 5; i++) begin
          checks++;
          if (dut_regs[i] !== model[i]) begin
            errors++; $display("FAIL random%0d_reg%0d: got %h expected %h", n, i, dut_regs[i], model[i]);
          end
        end
      end
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut_regs[i] !== model[i]) begin
        errors++; $display("FAIL random_final_reg%0d: got %h expected %h", i, dut_regs[i], model[i]);
      end
    end
    checks++;
    if (wr_seen !== exp_wr || err_seen !== exp_err) begin
      errors++; $display("FAIL random_strobe_totals: got wr=%0d err=%0d expected wr=%0d err=%0d",
                         wr_seen, err_seen, exp_wr, exp_err);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write();
    test_duty_updates();
    test_invalid_frames();
    test_latency();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
